seq_pattern_pipe: RTL and testbench
===================================

Name: seq_pattern_pipe

Overview:
Parametrised successor to the single-flop sequential pattern cells emitted by the graph-grammar flow. Evaluates the standard CLR-gated and-or-invert cone on WIDTH independent lanes and registers the result through a DEPTH-stage valid-tracked pipeline. Adds two features the single-flop cell lacks: a sticky (OR-accumulate) output mode and a saturating hit counter. Used as a leaf pattern inside generated test_final netlists.

Parameters:
WIDTH, 4, number of independent lanes (>=1)
DEPTH, 1, total register stages from input sample to v12 (>=1); DEPTH=1 is the legacy single-flop timing
CNT_W, 8, hit counter width (>=1)

Ports:
blif_clk_net  input  1  clock, rising edge
blif_reset_net  input  1  synchronous reset, active-high
CLR  input  1  global gate; 0 forces every lane result to 0
IN_1  input  WIDTH  cone input, per lane
IN_3  input  WIDTH  cone input, per lane
IN_5  input  WIDTH  cone input, per lane
IN_6  input  WIDTH  cone input, per lane
IN_8  input  WIDTH  cone input, per lane
in_valid  input  1  inputs are sampled this cycle
mode  input  1  0 = NORMAL (replace), 1 = STICKY (OR-accumulate)
sticky_clr  input  1  clears v12 (takes effect in both modes)
cnt_clr  input  1  clears hit_count
v12  output  WIDTH  registered lane results
v12_valid  output  1  one-cycle pulse when v12 is updated from the pipeline
hit_count  output  CNT_W  saturating count of nonzero results
any_hit  output  1  registered OR-reduce of v12

Behaviour:
- Lane function, bitwise: f = CLR & ~(IN_5 & IN_3 & ~IN_1 & ~(IN_6 & ~IN_8)).
- Reset (sampled on the clock edge while blif_reset_net=1): all pipeline data and valid bits, v12, v12_valid, hit_count and any_hit become 0. Reset overrides every other input. In-flight results are discarded, and no v12_valid is emitted for them after reset.
- Pipeline: stages 0..DEPTH-2 hold {data, vld} and shift every cycle with no stall.
  - Stage 0 loads data = in_valid ? f : 0 and vld = in_valid.
  - The output register is stage DEPTH-1. With DEPTH=1 it captures f directly.
- Latency: inputs sampled at edge N update v12 at edge N+DEPTH-1, so v12 is visible DEPTH cycles after the inputs are applied. Throughput is 1 per cycle.
- Output update, when the last pipe vld=1 (or in_valid=1 for DEPTH=1), with d = incoming data:
  - NORMAL: v12 <= d.
  - STICKY: v12 <= v12 | d.
  - sticky_clr coincident with an update: v12 <= d, ignoring the old value in both modes.
  - v12_valid = 1 for exactly that cycle.
- No update cycle: v12 holds, v12_valid = 0. If sticky_clr=1, v12 <= 0 and v12_valid stays 0.
- mode is sampled at the output update. A change of mode takes effect on the next update without flushing the pipeline.
- hit_count: increments on each update where d != 0. Saturates at 2^CNT_W-1 and holds there.
  - cnt_clr alone: hit_count <= 0.
  - cnt_clr together with a counting update: hit_count <= 1.
- any_hit is registered. It equals |v12 one cycle after v12 changes, and is 0 after reset.
- Lane independence: no lane affects another lane. CLR applies to all lanes and is sampled with the inputs, at stage 0.

Decomposition:
- Package seq_pattern_pkg:
  - mode_e enum {MODE_NORMAL=0, MODE_STICKY=1}
  - pure function cone_f(clr, in1, in3, in5, in6, in8), the WIDTH-generic lane function
- Sub-module seq_pattern_satcnt (parameter CNT_W; inputs inc, clr; output count) implements the saturating counter and its clear/increment priority.
- Pipeline stages are a generate loop inside seq_pattern_pipe.

Test Plan:
1. Reset: hold blif_reset_net=1 for 2 cycles with in_valid=1 and random inputs -> v12=0, v12_valid=0, hit_count=0, any_hit=0.
2. Cone and latency (WIDTH=4, DEPTH=2):
   - Apply CLR=1, IN_3=IN_5=4'hF, IN_1=0, IN_8=0, IN_6=4'b0101, in_valid=1 for one cycle -> v12=4'h5 with a v12_valid pulse exactly 2 cycles later.
   - Repeat with IN_6=0 -> v12=4'h0 and hit_count unchanged.
3. CLR gate: same stimulus as scenario 2 with CLR=0 and IN_6=4'b0101 -> v12=4'h0 and no hit_count increment.
4. Sticky mode (mode=1):
   - Results 4'h1 then 4'h4 -> v12=4'h5 and any_hit=1.
   - sticky_clr alone -> v12=0 and v12_valid=0.
   - sticky_clr coincident with result 4'h2 -> v12=4'h2.
5. Counter (CNT_W=3):
   - 9 consecutive nonzero results -> hit_count reaches 7 and holds.
   - cnt_clr coincident with a nonzero result -> hit_count=1.
   - in_valid gap cycles -> no change.
6. Reset mid-flight (DEPTH=3): in_valid=1 with a nonzero result, then reset on the next edge -> no v12_valid pulse for that result, and v12=0 afterwards.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared types and the per-lane and-or-invert cone used by the sequential pattern pipe.
// Pure combinational helpers only; no state lives here.
package seq_pattern_pkg;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_STICKY = 1'b1
  } mode_e;

  // Bitwise cone; callers apply it lane by lane so any WIDTH is supported.
  function automatic logic cone_f(
    input logic clr,
    input logic in1,
    input logic in3,
    input logic in5,
    input logic in6,
    input logic in8
  );
    return clr & ~(in5 & in3 & ~in1 & ~(in6 & ~in8));
  endfunction

endpackage

// File: rtl/seq_pattern_satcnt.sv
// Saturating up-counter: clear wins over the held value, but a coincident increment counts as one.
// One cycle from inc/clr to count; never stalls.
module seq_pattern_satcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_pipe.sv
// WIDTH-lane CLR-gated cone registered through DEPTH valid-tracked stages, with sticky output and hit counter.
// Inputs sampled at edge N reach v12 at edge N+DEPTH-1; free-running pipe, no backpressure.
module seq_pattern_pipe
  import seq_pattern_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             CLR,
  input  logic [WIDTH-1:0] IN_1,
  input  logic [WIDTH-1:0] IN_3,
  input  logic [WIDTH-1:0] IN_5,
  input  logic [WIDTH-1:0] IN_6,
  input  logic [WIDTH-1:0] IN_8,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             sticky_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] v12,
  output logic             v12_valid,
  output logic [CNT_W-1:0] hit_count,
  output logic             any_hit
);

  logic [WIDTH-1:0] f;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    assign f[l] = cone_f(CLR, IN_1[l], IN_3[l], IN_5[l], IN_6[l], IN_8[l]);
  end

  // chain[0] is the stage-0 input; chain[s+1] is the output of stage s.
  logic [WIDTH-1:0] chain_dat [DEPTH];
  logic             chain_vld [DEPTH];

  assign chain_dat[0] = in_valid ? f : '0;
  assign chain_vld[0] = in_valid;

  for (genvar s = 0; s < DEPTH - 1; s++) begin : g_stage
    logic [WIDTH-1:0] dat_q;
    logic             vld_q;

    always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
        dat_q <= '0;
        vld_q <= 1'b0;
      end else begin
        dat_q <= chain_dat[s];
        vld_q <= chain_vld[s];
      end
    end

    assign chain_dat[s+1] = dat_q;
    assign chain_vld[s+1] = vld_q;
  end

  logic [WIDTH-1:0] upd_dat;
  logic             upd_vld;
  logic [WIDTH-1:0] v12_q;
  logic [WIDTH-1:0] v12_d;
  logic             v12_valid_q;
  logic             any_hit_q;

  assign upd_dat = chain_dat[DEPTH-1];
  assign upd_vld = chain_vld[DEPTH-1];

  always_comb begin
    v12_d = v12_q;
    if (upd_vld) begin
      if (sticky_clr || (mode_e'(mode) == MODE_NORMAL)) v12_d = upd_dat;
      else                                               v12_d = v12_q | upd_dat;
    end else if (sticky_clr) begin
      v12_d = '0;
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      v12_q       <= '0;
      v12_valid_q <= 1'b0;
      any_hit_q   <= 1'b0;
    end else begin
      v12_q       <= v12_d;
      v12_valid_q <= upd_vld;
      any_hit_q   <= |v12_q;
    end
  end

  seq_pattern_satcnt #(
    .CNT_W (CNT_W)
  ) u_satcnt (
    .clk   (blif_clk_net),
    .rst   (blif_reset_net),
    .inc   (upd_vld && (upd_dat != '0)),
    .clr   (cnt_clr),
    .count (hit_count)
  );

  assign v12       = v12_q;
  assign v12_valid = v12_valid_q;
  assign any_hit   = any_hit_q;

endmodule

// File: tb/tb_seq_pattern_pipe.sv
// Directed bench for seq_pattern_pipe: a DEPTH=2/CNT_W=3 instance for most scenarios,
// plus a DEPTH=3 instance sharing the same inputs for latency and reset-in-flight checks.
module tb_seq_pattern_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] in1, in3, in5, in6, in8;
  logic       in_valid, mode, sticky_clr, cnt_clr;

  logic [3:0] d2_v12, d3_v12;
  logic       d2_vld, d3_vld, d2_any, d3_any;
  logic [2:0] d2_hit, d3_hit;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(3)) dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .CLR(clr),
    .IN_1(in1), .IN_3(in3), .IN_5(in5), .IN_6(in6), .IN_8(in8),
    .in_valid(in_valid), .mode(mode), .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .v12(d2_v12), .v12_valid(d2_vld), .hit_count(d2_hit), .any_hit(d2_any)
  );

  seq_pattern_pipe #(.WIDTH(4), .DEPTH(3), .CNT_W(3)) dut3 (
    .blif_clk_net(clk), .blif_reset_net(rst), .CLR(clr),
    .IN_1(in1), .IN_3(in3), .IN_5(in5), .IN_6(in6), .IN_8(in8),
    .in_valid(in_valid), .mode(mode), .sticky_clr(sticky_clr), .cnt_clr(cnt_clr),
    .v12(d3_v12), .v12_valid(d3_vld), .hit_count(d3_hit), .any_hit(d3_any)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With IN_3=IN_5=F, IN_1=IN_8=0 the cone reduces to f = CLR & IN_6.
  task automatic set_res(input logic [3:0] r);
    in3 = 4'hF; in5 = 4'hF; in1 = 4'h0; in8 = 4'h0; in6 = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; clr = 1'b1; mode = 1'b0; sticky_clr = 1'b0; cnt_clr = 1'b0;
    in1 = 4'($urandom); in3 = 4'($urandom); in5 = 4'($urandom); in6 = 4'($urandom); in8 = 4'($urandom);
    tick();
    in6 = 4'($urandom);
    tick();
    checks++; if (d2_v12 !== 4'h0) begin failures++; $display("FAIL reset_v12 got=%h exp=0", d2_v12); end
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", d2_vld); end
    checks++; if (d2_hit !== 3'd0) begin failures++; $display("FAIL reset_hit got=%0d exp=0", d2_hit); end
    checks++; if (d2_any !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", d2_any); end
    checks++; if (d3_vld !== 1'b0) begin failures++; $display("FAIL reset_d3_vld got=%b exp=0", d3_vld); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL reset_release_vld got=%b exp=0", d2_vld); end
    tick();
  endtask

  task automatic test_cone();
    set_res(4'b0101); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL cone_early_vld got=%b exp=0", d2_vld); end
    tick();
    checks++; if (d2_v12 !== 4'h5) begin failures++; $display("FAIL cone_v12 got=%h exp=5", d2_v12); end
    checks++; if (d2_vld !== 1'b1) begin failures++; $display("FAIL cone_vld got=%b exp=1", d2_vld); end
    checks++; if (d2_hit !== 3'd1) begin failures++; $display("FAIL cone_hit got=%0d exp=1", d2_hit); end
    tick();
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL cone_pulse_len got=%b exp=0", d2_vld); end
    checks++; if (d2_any !== 1'b1) begin failures++; $display("FAIL cone_any got=%b exp=1", d2_any); end
    set_res(4'h0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (d2_v12 !== 4'h0) begin failures++; $display("FAIL cone_zero_v12 got=%h exp=0", d2_v12); end
    checks++; if (d2_vld !== 1'b1) begin failures++; $display("FAIL cone_zero_vld got=%b exp=1", d2_vld); end
    checks++; if (d2_hit !== 3'd1) begin failures++; $display("FAIL cone_zero_hit got=%0d exp=1", d2_hit); end
    tick();
    checks++; if (d2_any !== 1'b0) begin failures++; $display("FAIL cone_zero_any got=%b exp=0", d2_any); end
  endtask

  task automatic test_clr_gate();
    clr = 1'b0; set_res(4'b0101); in_valid = 1'b1;
    tick();
    clr = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (d2_v12 !== 4'h0) begin failures++; $display("FAIL clr_v12 got=%h exp=0", d2_v12); end
    checks++; if (d2_vld !== 1'b1) begin failures++; $display("FAIL clr_vld got=%b exp=1", d2_vld); end
    checks++; if (d2_hit !== 3'd1) begin failures++; $display("FAIL clr_hit got=%0d exp=1", d2_hit); end
    tick();
  endtask

  task automatic test_sticky();
    mode = 1'b1;
    set_res(4'h1); in_valid = 1'b1;
    tick();
    set_res(4'h4);
    tick();
    in_valid = 1'b0;
    checks++; if (d2_v12 !== 4'h1) begin failures++; $display("FAIL sticky_first got=%h exp=1", d2_v12); end
    tick();
    checks++; if (d2_v12 !== 4'h5) begin failures++; $display("FAIL sticky_accum got=%h exp=5", d2_v12); end
    tick();
    checks++; if (d2_any !== 1'b1) begin failures++; $display("FAIL sticky_any got=%b exp=1", d2_any); end
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    checks++; if (d2_v12 !== 4'h0) begin failures++; $display("FAIL sticky_clr_v12 got=%h exp=0", d2_v12); end
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL sticky_clr_vld got=%b exp=0", d2_vld); end
    set_res(4'h8); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (d2_v12 !== 4'h8) begin failures++; $display("FAIL sticky_reload got=%h exp=8", d2_v12); end
    set_res(4'h2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    checks++; if (d2_v12 !== 4'h2) begin failures++; $display("FAIL sticky_clr_upd got=%h exp=2", d2_v12); end
    checks++; if (d2_vld !== 1'b1) begin failures++; $display("FAIL sticky_clr_upd_vld got=%b exp=1", d2_vld); end
    checks++; if (d2_hit !== 3'd5) begin failures++; $display("FAIL sticky_hit got=%0d exp=5", d2_hit); end
    mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_res(4'h5); in_valid = 1'b1;
    tick();
    set_res(4'hA);
    tick();
    checks++; if (d2_v12 !== 4'h5 || d2_vld !== 1'b1) begin failures++; $display("FAIL b2b_0 got=%h/%b exp=5/1", d2_v12, d2_vld); end
    set_res(4'h3);
    tick();
    in_valid = 1'b0;
    checks++; if (d2_v12 !== 4'hA || d2_vld !== 1'b1) begin failures++; $display("FAIL b2b_1 got=%h/%b exp=a/1", d2_v12, d2_vld); end
    tick();
    checks++; if (d2_v12 !== 4'h3 || d2_vld !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%b exp=3/1", d2_v12, d2_vld); end
    tick();
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL b2b_end_vld got=%b exp=0", d2_vld); end
    checks++; if (d2_hit !== 3'd7) begin failures++; $display("FAIL b2b_hit got=%0d exp=7", d2_hit); end
  endtask

  task automatic test_counter();
    int exp_hit;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (d2_hit !== 3'd0) begin failures++; $display("FAIL cnt_clr_alone got=%0d exp=0", d2_hit); end
    set_res(4'h1); in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_hit = (i > 7) ? 7 : i;
      checks++; if (d2_hit !== 3'(exp_hit)) begin failures++; $display("FAIL cnt_step%0d got=%0d exp=%0d", i, d2_hit, exp_hit); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (d2_hit !== 3'd7) begin failures++; $display("FAIL cnt_sat got=%0d exp=7", d2_hit); end
    set_res(4'h3); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (d2_hit !== 3'd1) begin failures++; $display("FAIL cnt_clr_inc got=%0d exp=1", d2_hit); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (d2_hit !== 3'd1) begin failures++; $display("FAIL cnt_gap_hit got=%0d exp=1", d2_hit); end
    checks++; if (d2_v12 !== 4'h3 || d2_vld !== 1'b0) begin failures++; $display("FAIL cnt_gap_v12 got=%h/%b exp=3/0", d2_v12, d2_vld); end
  endtask

  task automatic test_depth3();
    set_res(4'h9); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (d3_vld !== 1'b0) begin failures++; $display("FAIL d3_early_vld got=%b exp=0", d3_vld); end
    tick();
    checks++; if (d3_v12 !== 4'h9 || d3_vld !== 1'b1) begin failures++; $display("FAIL d3_latency got=%h/%b exp=9/1", d3_v12, d3_vld); end
    tick();
  endtask

  task automatic test_reset_midflight();
    int pulses = 0;
    set_res(4'h6); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (d2_vld !== 1'b0) begin failures++; $display("FAIL mid_d2_vld got=%b exp=0", d2_vld); end
    for (int i = 0; i < 4; i++) begin
      if (d3_vld !== 1'b0) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mid_d3_pulses got=%0d exp=0", pulses); end
    checks++; if (d3_v12 !== 4'h0) begin failures++; $display("FAIL mid_d3_v12 got=%h exp=0", d3_v12); end
    checks++; if (d3_hit !== 3'd0) begin failures++; $display("FAIL mid_d3_hit got=%0d exp=0", d3_hit); end
    checks++; if (d2_v12 !== 4'h0 || d2_any !== 1'b0) begin failures++; $display("FAIL mid_d2_state got=%h/%b exp=0/0", d2_v12, d2_any); end
  endtask

  initial begin
    test_reset();
    test_cone();
    test_clr_gate();
    test_sticky();
    test_back_to_back();
    test_counter();
    test_depth3();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
